// File: rtl/pipelined_csa_adder.sv
// Pipelined square-root carry-select adder with valid/ready handshake, clocked on the falling edge.
// Optional subtract mode is enabled by defining CSA_SUB_EN (adds the 'sub' port).
module pipelined_csa_adder #(
    parameter int WIDTH = 26,
    parameter int BLK0  = 2,
    parameter int PIPE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_input,
    input  logic [WIDTH-1:0] b_input,
    input  logic             c_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH:0]   sum_output,
    output logic             out_valid,
    input  logic             out_ready
`ifdef CSA_SUB_EN
    ,
    input  logic             sub
`endif
);

    // Block k starts at bit k*BLK0 + k*(k-1)/2 (sizes BLK0, BLK0+1, ...).
    function automatic int blk_lo(input int k);
        return (k * BLK0) + ((k * (k - 32'sd1)) / 32'sd2);
    endfunction

    function automatic int blk_of(input int bit_idx);
        int idx;
        idx = 32'sd0;
        for (int k = 0; k < WIDTH; k++) begin
            idx = (bit_idx >= blk_lo(k + 32'sd1)) ? (k + 32'sd1) : idx;
        end
        return idx;
    endfunction

    localparam int NBLK = blk_of(WIDTH - 32'sd1) + 32'sd1;
    localparam int NST  = PIPE + 2;

    function automatic int seg_bound(input int s);
        return (s * NBLK) / (PIPE + 32'sd1);
    endfunction

    // Carry-select over blocks [blo, bhi): each block ripples for carry 0 and 1, then
    // selects on the incoming block carry. Bits outside the range pass through from ps.
    function automatic logic [WIDTH:0] seg_add(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] ps,
        input logic             cin,
        input int               blo,
        input int               bhi
    );
        logic [WIDTH-1:0] res;
        logic cblk, c0, c1, s0, s1, blk_start, blk_end;
        int   bi;
        res  = ps;
        cblk = cin;
        c0   = 1'b0;
        c1   = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            bi = blk_of(i);
            if ((bi >= blo) && (bi < bhi)) begin
                blk_start = (i == blk_lo(bi));
                blk_end   = (i == (blk_lo(bi + 32'sd1) - 32'sd1)) || (i == (WIDTH - 32'sd1));
                c0     = blk_start ? 1'b0 : c0;
                c1     = blk_start ? 1'b1 : c1;
                s0     = a[i] ^ b[i] ^ c0;
                s1     = a[i] ^ b[i] ^ c1;
                c0     = (a[i] & b[i]) | (a[i] & c0) | (b[i] & c0);
                c1     = (a[i] & b[i]) | (a[i] & c1) | (b[i] & c1);
                res[i] = cblk ? s1 : s0;
                cblk   = blk_end ? (cblk ? c1 : c0) : cblk;
            end else begin
                res[i] = res[i];
            end
        end
        return {cblk, res};
    endfunction

    logic             rdy_en_q, rdy_en_d;
    logic [NST-1:0]   v_q, v_d, en_s;
    logic [WIDTH-1:0] a_q [PIPE+1];
    logic [WIDTH-1:0] a_d [PIPE+1];
    logic [WIDTH-1:0] b_q [PIPE+1];
    logic [WIDTH-1:0] b_d [PIPE+1];
    logic [WIDTH-1:0] ps_q [PIPE+1];
    logic [WIDTH-1:0] ps_d [PIPE+1];
    logic [PIPE:0]    c_q, c_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic [WIDTH:0]   seg_s [PIPE+1];
    logic [WIDTH-1:0] b0_eff_s;
    logic             c0_eff_s;
    logic             ld0_s;
`ifdef CSA_SUB_EN
    logic             sub_q, sub_d;
`endif

    // Stage enables: a stage may load when it is empty or its successor loads this edge.
    always_comb begin
        logic en_t;
        en_t           = (~v_q[NST-1]) | out_ready;
        en_s           = {NST{1'b0}};
        en_s[NST-1]    = en_t;
        for (int k = NST - 2; k >= 0; k--) begin
            en_t    = (~v_q[k]) | en_t;
            en_s[k] = en_t;
        end
    end

    assign in_ready = rdy_en_q & en_s[0];

    // Operand conditioning for subtract, then the carry-select segment owned by each stage.
    always_comb begin
        b0_eff_s = b_q[0];
        c0_eff_s = c_q[0];
`ifdef CSA_SUB_EN
        if (sub_q) begin
            b0_eff_s = ~b_q[0];
            c0_eff_s = 1'b1;
        end else begin
            b0_eff_s = b_q[0];
            c0_eff_s = c_q[0];
        end
`endif
        for (int s = 0; s <= PIPE; s++) begin
            seg_s[s] = seg_add(a_q[s], (s == 0) ? b0_eff_s : b_q[s], ps_q[s],
                               (s == 0) ? c0_eff_s : c_q[s], seg_bound(s), seg_bound(s + 1));
        end
    end

    // Next-state for valid bits and stage payloads; payload only moves with a valid token.
    always_comb begin
        rdy_en_d = 1'b1;
        v_d      = v_q;
        a_d      = a_q;
        b_d      = b_q;
        ps_d     = ps_q;
        c_d      = c_q;
        sum_d    = sum_q;
        ps_d[0]  = {WIDTH{1'b0}};
        ld0_s    = en_s[0] & in_valid & rdy_en_q;
`ifdef CSA_SUB_EN
        sub_d    = sub_q;
`endif
        if (en_s[0]) begin
            v_d[0] = in_valid & rdy_en_q;
        end else begin
            v_d[0] = v_q[0];
        end
        if (ld0_s) begin
            a_d[0] = a_input;
            b_d[0] = b_input;
            c_d[0] = c_in;
`ifdef CSA_SUB_EN
            sub_d  = sub;
`endif
        end else begin
            a_d[0] = a_q[0];
        end
        for (int k = 1; k <= PIPE; k++) begin
            if (en_s[k]) begin
                v_d[k] = v_q[k-1];
            end else begin
                v_d[k] = v_q[k];
            end
            // Register the partial sum, pending carry and the operands still to be processed.
            if (en_s[k] & v_q[k-1]) begin
                a_d[k]  = a_q[k-1];
                b_d[k]  = (k == 1) ? b0_eff_s : b_q[k-1];
                ps_d[k] = seg_s[k-1][WIDTH-1:0];
                c_d[k]  = seg_s[k-1][WIDTH];
            end else begin
                a_d[k]  = a_q[k];
            end
        end
        if (en_s[NST-1]) begin
            v_d[NST-1] = v_q[PIPE];
        end else begin
            v_d[NST-1] = v_q[NST-1];
        end
        if (en_s[NST-1] & v_q[PIPE]) begin
            sum_d = seg_s[PIPE];
        end else begin
            sum_d = sum_q;
        end
    end

    // Falling-edge state registers with asynchronous active-low clear.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            rdy_en_q <= 1'b0;
            v_q      <= {NST{1'b0}};
            c_q      <= {(PIPE+1){1'b0}};
            sum_q    <= {(WIDTH+1){1'b0}};
`ifdef CSA_SUB_EN
            sub_q    <= 1'b0;
`endif
            for (int k = 0; k <= PIPE; k++) begin
                a_q[k]  <= {WIDTH{1'b0}};
                b_q[k]  <= {WIDTH{1'b0}};
                ps_q[k] <= {WIDTH{1'b0}};
            end
        end else begin
            rdy_en_q <= rdy_en_d;
            v_q      <= v_d;
            c_q      <= c_d;
            sum_q    <= sum_d;
`ifdef CSA_SUB_EN
            sub_q    <= sub_d;
`endif
            for (int k = 0; k <= PIPE; k++) begin
                a_q[k]  <= a_d[k];
                b_q[k]  <= b_d[k];
                ps_q[k] <= ps_d[k];
            end
        end
    end

    assign sum_output = sum_q;
    assign out_valid  = v_q[NST-1];

endmodule
